alu_seq_ctrl: RTL



---
 rtl/alu_seq_ctrl_if.sv | 32 +++
 rtl/alu_seq_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake plus decoded datapath controls between the
// instruction source, the sequencing controller and the RegFile/ALU pair.
interface alu_seq_ctrl_if;
  logic [15:0] inst_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [4:0]  Flags_in;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [3:0]  OpCode;
  logic        En;
  logic [4:0]  psr;
  logic        busy;
  logic        done;
  logic [15:0] icount;

  // Instruction source / datapath side
  modport master (
    output inst_in, inst_valid, Flags_in,
    input  inst_ready, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode,
           En, psr, busy, done, icount
  );

  // Controller side
  modport slave (
    input  inst_in, inst_valid, Flags_in,
    output inst_ready, RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode,
           En, psr, busy, done, icount
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the RegFile/ALU datapath.
// Accepts one instruction per handshake, decodes it into registered fields,
// walks IDLE -> DECODE -> EXEC -> DONE and captures ALU flags into psr.
//
//   state  | meaning
//   IDLE   | ready for a new instruction, fields hold last decode
//   DECODE | datapath settles on the latched fields
//   EXEC   | write enable pulse (unless NOP/CMP), flags captured on exit
//   DONE   | completion pulse, retired count advanced on exit
module alu_seq_ctrl #(
  parameter logic [15:0] IcountResetVal = 16'h0000
) (
  input logic           Clk,
  input logic           Rst,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [3:0] CMP_OP = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT       state;
  stateT       nextState;

  logic [3:0]  rdestReg;
  logic [3:0]  rsrcReg;
  logic [15:0] immReg;
  logic        immSelReg;
  logic [3:0]  opCodeReg;
  logic        isNop;
  logic [4:0]  psrReg;
  logic [15:0] icountReg;

  logic        accept;

  assign accept = (state == IDLE) && bus.inst_valid;

  // State register; reset returns to IDLE immediately, aborting any write.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state sequencing: fixed four-step walk, only IDLE looks at inst_valid.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.inst_valid) nextState = DECODE;
      DECODE:  nextState = EXEC;
      EXEC:    nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Decode the instruction at the accept edge; fields then hold until the next accept.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdestReg  <= 4'h0;
      rsrcReg   <= 4'h0;
      immReg    <= 16'h0000;
      immSelReg <= 1'b0;
      opCodeReg <= 4'h0;
      isNop     <= 1'b0;
    end else if (accept) begin
      rdestReg <= bus.inst_in[11:8];
      isNop    <= (bus.inst_in == 16'h0000);
      if (bus.inst_in[15:12] == 4'h0) begin
        opCodeReg <= bus.inst_in[7:4];
        rsrcReg   <= bus.inst_in[3:0];
        immSelReg <= 1'b0;
        immReg    <= 16'h0000;
      end else begin
        opCodeReg <= bus.inst_in[15:12];
        rsrcReg   <= 4'h0;
        immSelReg <= 1'b1;
        immReg    <= {{8{bus.inst_in[7]}}, bus.inst_in[7:0]};
      end
    end
  end

  // Status capture on the edge leaving EXEC; a NOP leaves the flags alone.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                          psrReg <= 5'h00;
    else if (state == EXEC && !isNop)  psrReg <= bus.Flags_in;
  end

  // Retired-instruction counter, bumped on the edge leaving DONE; wraps freely.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                icountReg <= IcountResetVal;
    else if (state == DONE)  icountReg <= icountReg + 16'h0001;
  end

  assign bus.inst_ready  = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.En          = (state == EXEC) && !isNop && (opCodeReg != CMP_OP);
  assign bus.RdestRegLoc = rdestReg;
  assign bus.RsrcRegLoc  = rsrcReg;
  assign bus.Imm         = immReg;
  assign bus.Imm_s       = immSelReg;
  assign bus.OpCode      = opCodeReg;
  assign bus.psr         = psrReg;
  assign bus.icount      = icountReg;

endmodule
